// File: rtl/key_scheduler.sv
// key_scheduler
//   Emits NUM_ROUNDS+1 round keys derived from a 20-bit cipher key, one key per
//   valid/ready handshake. Each key after the first is the previous key
//   rotated right by 7, with the top nibble passed through the PRESENT S-box
//   and bits [7:4] XORed with the LSB of the new round index.
//
//   Optional feature: define KEY_SCHED_RELOAD_EN to let a load arriving while
//   keys are still being emitted restart the sequence. A same-cycle handshake
//   is then ignored. Without the macro, a load during emission is ignored.
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   asynchronous active-high reset
//   key_in     in   [19:0] initial key, sampled on an accepted load
//   load       in   start request
//   round_key  out  [19:0] current round key (registered)
//   round_idx  out  [4:0]  index of round_key, 0..NUM_ROUNDS (registered)
//   rk_valid   out  round_key/round_idx valid
//   rk_ready   in   consumer accepts; handshake = rk_valid & rk_ready
//   busy       out  high while keys are being emitted
//   done       out  one-cycle pulse after the final key handshake
module key_scheduler #(
  parameter int NUM_ROUNDS = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] key_in,
  input  logic        load,
  output logic [19:0] round_key,
  output logic [4:0]  round_idx,
  output logic        rk_valid,
  input  logic        rk_ready,
  output logic        busy,
  output logic        done
);

  localparam int         KEY_W    = 20;
  localparam logic [4:0] LAST_IDX = 5'(NUM_ROUNDS);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EMIT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [4:0]       idx_q, idx_d;
  logic             done_q, done_d;

  logic             hs;
  logic             load_acc;
  logic [4:0]       idx_inc;

  // PRESENT 4-bit S-box
  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0:    return 4'hC;
      4'h1:    return 4'h5;
      4'h2:    return 4'h6;
      4'h3:    return 4'hB;
      4'h4:    return 4'h9;
      4'h5:    return 4'h0;
      4'h6:    return 4'hA;
      4'h7:    return 4'hD;
      4'h8:    return 4'h3;
      4'h9:    return 4'hE;
      4'hA:    return 4'hF;
      4'hB:    return 4'h8;
      4'hC:    return 4'h4;
      4'hD:    return 4'h7;
      4'hE:    return 4'h1;
      default: return 4'h2;
    endcase
  endfunction

  // One key-schedule step: rotate right by 7, S-box the top nibble,
  // fold the round-index LSB into bits [7:4].
  function automatic logic [KEY_W-1:0] update_key(input logic [KEY_W-1:0] k,
                                                  input logic             b);
    logic [KEY_W-1:0] t;
    t        = {k[6:0], k[19:7]};
    t[19:16] = sbox(t[19:16]);
    t[7:4]   = t[7:4] ^ {4{b}};
    return t;
  endfunction

  assign hs      = (state_q == ST_EMIT) && rk_ready;
  assign idx_inc = idx_q + 5'd1;

`ifdef KEY_SCHED_RELOAD_EN
  assign load_acc = load;
`else
  assign load_acc = load && (state_q == ST_IDLE);
`endif

  // Next-state: an accepted load wins over a same-cycle handshake.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    if (load_acc) begin
      state_d = ST_EMIT;
      key_d   = key_in;
      idx_d   = 5'd0;
    end else if (hs) begin
      if (idx_q == LAST_IDX) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end else begin
        key_d = update_key(key_q, idx_inc[0]);
        idx_d = idx_inc;
      end
    end
  end

  // State registers: key/idx keep their last values in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  assign round_key = key_q;
  assign round_idx = idx_q;
  assign rk_valid  = (state_q == ST_EMIT);
  assign busy      = (state_q == ST_EMIT);
  assign done      = done_q;

endmodule

// File: tb/tb_key_scheduler.sv
// Testbench for key_scheduler: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level
// model that precomputes the whole key sequence on each accepted load.
module tb_key_scheduler;

  localparam int NR = 31;
`ifdef KEY_SCHED_RELOAD_EN
  localparam bit RELOAD = 1'b1;
`else
  localparam bit RELOAD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        load, rk_ready;
  logic [19:0] key_in;
  logic [19:0] round_key;
  logic [4:0]  round_idx;
  logic        rk_valid, busy, done;

  // Second instance with the smallest legal round count
  logic        load1, ready1;
  logic [19:0] key1;
  logic [19:0] round_key1;
  logic [4:0]  round_idx1;
  logic        rk_valid1, busy1, done1;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  key_scheduler #(.NUM_ROUNDS(NR)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .load(load),
    .round_key(round_key), .round_idx(round_idx), .rk_valid(rk_valid),
    .rk_ready(rk_ready), .busy(busy), .done(done)
  );

  key_scheduler #(.NUM_ROUNDS(1)) dut1 (
    .clk(clk), .rst(rst), .key_in(key1), .load(load1),
    .round_key(round_key1), .round_idx(round_idx1), .rk_valid(rk_valid1),
    .rk_ready(ready1), .busy(busy1), .done(done1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [19:0] m_upd(input logic [19:0] k, input int b);
    logic [63:0] tbl;
    logic [19:0] t;
    int          hi;
    tbl = 64'hC56B90AD3EF84712;          // S(0) in the top nibble
    t   = 20'((k >> 7) | (k << 13));
    hi  = int'(t[19:16]);
    t[19:16] = tbl[63 - 4*hi -: 4];
    if (b != 0) t = t ^ 20'h000F0;
    return t;
  endfunction

  function automatic logic [32*20-1:0] build_seq(input logic [19:0] k0);
    logic [32*20-1:0] r;
    logic [19:0]      k;
    r = '0;
    k = k0;
    for (int i = 0; i < 32; i++) begin
      r[i*20 +: 20] = k;
      k = m_upd(k, (i + 1) & 1);
    end
    return r;
  endfunction

  logic [32*20-1:0] m_seq;
  logic [19:0]      m_key;
  int               m_idx;
  bit               m_vld, m_done;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_vld  <= 1'b0;
      m_idx  <= 0;
      m_key  <= '0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (load && (!m_vld || RELOAD)) begin
        m_seq <= build_seq(key_in);
        m_vld <= 1'b1;
        m_idx <= 0;
        m_key <= key_in;
      end else if (m_vld && rk_ready) begin
        if (m_idx == NR) begin
          m_vld  <= 1'b0;
          m_done <= 1'b1;
        end else begin
          m_idx <= m_idx + 1;
          m_key <= m_seq[(m_idx + 1)*20 +: 20];
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("rk_valid",  {31'b0, rk_valid}, {31'b0, m_vld});
      chk("busy",      {31'b0, busy},     {31'b0, m_vld});
      chk("done",      {31'b0, done},     {31'b0, m_done});
      chk("round_idx", {27'b0, round_idx}, m_idx);
      chk("round_key", {12'b0, round_key}, {12'b0, m_key});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic run_to_done(input int budget, output int cyc, output int hs);
    cyc = 0;
    hs  = 0;
    while (done !== 1'b1 && cyc < budget) begin
      if (rk_valid && rk_ready) hs++;
      @(negedge clk);
      cyc++;
    end
    chk("done_within_budget", {31'b0, done}, 32'd1);
  endtask

  task automatic wait_idx(input int target, input int budget);
    int c;
    c = 0;
    while (!(rk_valid === 1'b1 && round_idx == 5'(target)) && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("reach_idx", {27'b0, round_idx}, target);
  endtask

  task automatic chk_out(input string tag, input logic [19:0] k, input int idx,
                         input bit v, input bit d);
    chk({tag, "_key"},   {12'b0, round_key}, {12'b0, k});
    chk({tag, "_idx"},   {27'b0, round_idx}, idx);
    chk({tag, "_valid"}, {31'b0, rk_valid},  {31'b0, v});
    chk({tag, "_busy"},  {31'b0, busy},      {31'b0, v});
    chk({tag, "_done"},  {31'b0, done},      {31'b0, d});
  endtask

  int          cyc, hs;
  logic [32*20-1:0] pin;
  logic [19:0] k1, k2;

  initial begin
    rst = 1'b1; load = 1'b0; rk_ready = 1'b0; key_in = '0;
    load1 = 1'b0; ready1 = 1'b0; key1 = '0;

    // Model pinned to hand-derived keys
    pin = build_seq(20'h00000);
    chk("model_k0", {12'b0, pin[0*20 +: 20]}, 32'h00000);
    chk("model_k1", {12'b0, pin[1*20 +: 20]}, 32'hC00F0);
    chk("model_k2", {12'b0, pin[2*20 +: 20]}, 32'h11801);

    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk_out("reset", 20'h0, 0, 1'b0, 1'b0);

    // Zero key, always ready; load on the first edge after reset release
    rst = 1'b0; load = 1'b1; key_in = 20'h00000; rk_ready = 1'b1;
    @(negedge clk); load = 1'b0;
    chk_out("z_idx0", 20'h00000, 0, 1'b1, 1'b0);
    @(negedge clk);
    chk_out("z_idx1", 20'hC00F0, 1, 1'b1, 1'b0);
    @(negedge clk);
    chk_out("z_idx2", 20'h11801, 2, 1'b1, 1'b0);
    run_to_done(60, cyc, hs);
    chk("z_cycles_to_done", cyc, 30);
    chk("z_handshakes", hs + 2, 32);
    chk_out("z_done", pin[31*20 +: 20], 31, 1'b0, 1'b1);
    @(negedge clk);
    chk_out("z_after_done", pin[31*20 +: 20], 31, 1'b0, 1'b0);

    // Backpressure on idx0 for five cycles
    load = 1'b1; key_in = 20'h00000; rk_ready = 1'b0;
    @(negedge clk); load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk_out("hold", 20'h00000, 0, 1'b1, 1'b0);
      @(negedge clk);
    end
    rk_ready = 1'b1;
    @(negedge clk);
    chk_out("release", 20'hC00F0, 1, 1'b1, 1'b0);
    run_to_done(60, cyc, hs);
    @(negedge clk);

    // Asynchronous reset in the middle of a sequence
    load = 1'b1; key_in = 20'h00000; rk_ready = 1'b1;
    @(negedge clk); load = 1'b0;
    wait_idx(10, 20);
    #2 rst = 1'b1;
    #1 chk_out("async_rst", 20'h0, 0, 1'b0, 1'b0);
    @(negedge clk);
    chk_out("rst_held", 20'h0, 0, 1'b0, 1'b0);
    rst = 1'b0; load = 1'b1; key_in = 20'h00000;
    @(negedge clk); load = 1'b0;
    chk_out("rl_idx0", 20'h00000, 0, 1'b1, 1'b0);
    @(negedge clk);
    chk_out("rl_idx1", 20'hC00F0, 1, 1'b1, 1'b0);
    run_to_done(60, cyc, hs);
    @(negedge clk);

    // load pulsed while emitting
    k1 = 20'($urandom);
    k2 = 20'($urandom) ^ 20'h5A5A5;
    load = 1'b1; key_in = k1; rk_ready = 1'b1;
    @(negedge clk); load = 1'b0;
    wait_idx(5, 20);
    load = 1'b1; key_in = k2;
    @(negedge clk); load = 1'b0;
    if (RELOAD) begin
      chk("mid_load_idx", {27'b0, round_idx}, 32'd0);
      chk("mid_load_key", {12'b0, round_key}, {12'b0, k2});
    end else begin
      pin = build_seq(k1);
      chk("mid_load_idx", {27'b0, round_idx}, 32'd6);
      chk("mid_load_key", {12'b0, round_key}, {12'b0, pin[6*20 +: 20]});
    end
    run_to_done(60, cyc, hs);
    @(negedge clk);
    chk("single_done", {31'b0, done}, 32'd0);

    // Randomized traffic with occasional asynchronous resets
    for (int i = 0; i < 3000; i++) begin
      rst      = 1'b0;
      rk_ready = ($urandom_range(0, 99) < 70);
      load     = ($urandom_range(0, 99) < 4);
      key_in   = 20'($urandom);
      if ($urandom_range(0, 249) == 0) begin
        #2 rst = 1'b1;
      end
      @(negedge clk);
    end
    rst = 1'b0; load = 1'b0; rk_ready = 1'b1;
    repeat (40) @(negedge clk);

    // NUM_ROUNDS = 1 instance: two keys, done, reload in the done cycle
    load1 = 1'b1; key1 = 20'h00000; ready1 = 1'b1;
    @(negedge clk); load1 = 1'b0;
    chk("n1_idx0_key", {12'b0, round_key1}, 32'h00000);
    chk("n1_idx0_idx", {27'b0, round_idx1}, 32'd0);
    chk("n1_idx0_vld", {31'b0, rk_valid1}, 32'd1);
    @(negedge clk);
    chk("n1_idx1_key", {12'b0, round_key1}, 32'hC00F0);
    chk("n1_idx1_idx", {27'b0, round_idx1}, 32'd1);
    @(negedge clk);
    chk("n1_done",     {31'b0, done1},     32'd1);
    chk("n1_done_vld", {31'b0, rk_valid1}, 32'd0);
    chk("n1_done_bsy", {31'b0, busy1},     32'd0);
    load1 = 1'b1; key1 = 20'h12345;
    @(negedge clk); load1 = 1'b0;
    chk("n1_reload_vld",  {31'b0, rk_valid1}, 32'd1);
    chk("n1_reload_key",  {12'b0, round_key1}, 32'h12345);
    chk("n1_reload_idx",  {27'b0, round_idx1}, 32'd0);
    chk("n1_reload_done", {31'b0, done1},      32'd0);
    repeat (3) @(negedge clk);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/key_scheduler.md
KEY_SCHEDULER -- requirements
Module: key_scheduler

Interface
REQ-001 SHALL provide parameter NUM_ROUNDS, default 31, the index of the last round key emitted; legal range 1..31.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port key_in  input  20  initial cipher key, sampled on an accepted load.
REQ-005 SHALL have port load  input  1  start request; accepted only as defined in REQ-012 and REQ-027.
REQ-006 SHALL have port round_key  output  20  current round key, registered.
REQ-007 SHALL have port round_idx  output  5  index of round_key, 0..NUM_ROUNDS, registered.
REQ-008 SHALL have port rk_valid  output  1  round_key/round_idx valid.
REQ-009 SHALL have port rk_ready  input  1  consumer accepts; handshake = rk_valid & rk_ready on a rising edge.
REQ-010 SHALL have port busy  output  1  high in state EMIT.
REQ-011 SHALL have port done  output  1  one-cycle pulse after the final key handshake.

Function
REQ-012 SHALL implement FSM states IDLE and EMIT; IDLE->EMIT on load=1; EMIT->IDLE on handshake with round_idx==NUM_ROUNDS.
REQ-013 On accepted load SHALL, next cycle: round_key=key_in, round_idx=0, rk_valid=1, busy=1.
REQ-014 On handshake with round_idx=r<NUM_ROUNDS SHALL, next cycle: round_key=update(round_key, lsb of r+1), round_idx=r+1, rk_valid stays 1.
REQ-015 update(k,b) SHALL be: t={k[6:0],k[19:7]}; t[19:16]=S(t[19:16]); t[7:4]=t[7:4] XOR {4{b}}; result t.
REQ-016 S SHALL be the PRESENT 4-bit S-box, inputs 0..F -> C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
REQ-017 While rk_valid=1 and rk_ready=0, round_key and round_idx SHALL hold stable.
REQ-018 On final handshake (round_idx==NUM_ROUNDS) SHALL, next cycle: rk_valid=0, busy=0, done=1 for exactly one cycle, state IDLE.
REQ-019 Total keys per load SHALL be NUM_ROUNDS+1; no key is skipped or repeated.
REQ-020 load in the same cycle done is high SHALL be accepted (state is IDLE).
REQ-021 rk_ready while rk_valid=0 SHALL have no effect.
REQ-022 round_key and round_idx SHALL retain their last values in IDLE.

Reset
REQ-023 rst=1 SHALL immediately, independent of clk, force state IDLE, round_key=0, round_idx=0, rk_valid=0, busy=0, done=0.
REQ-024 rst asserted mid-sequence SHALL abort it with no done pulse; the next load restarts from index 0.
REQ-025 load sampled on the first edge after rst deasserts SHALL be honoured.

Configuration
REQ-026 Macro KEY_SCHED_RELOAD_EN SHALL select reload-while-busy behaviour.
REQ-027 With KEY_SCHED_RELOAD_EN defined: load=1 in EMIT SHALL restart per REQ-013 with no done pulse, and load SHALL take priority over a same-cycle handshake.
REQ-028 Without KEY_SCHED_RELOAD_EN: load in EMIT SHALL be ignored and the sequence SHALL continue undisturbed.

Verification
REQ-029 key_in=0x00000, load, rk_ready=1 -> keys idx0=0x00000, idx1=0xC00F0, idx2=0x11801; done pulses one cycle after the idx31 handshake; 32 handshakes total.
REQ-030 After idx0 is presented, hold rk_ready=0 for 5 cycles -> round_key=0x00000, round_idx=0, rk_valid=1 stable throughout; release -> idx1=0xC00F0 next cycle.
REQ-031 Assert rst asynchronously at idx=10 -> outputs zero before the next edge, no done; reload key 0x00000 -> idx1=0xC00F0 again.
REQ-032 load pulsed at idx=5 -> without macro the sequence continues to idx31 with a single done; with KEY_SCHED_RELOAD_EN, idx=0 next cycle with round_key=new key_in.
REQ-033 NUM_ROUNDS=1, key_in=0x00000 -> idx0=0x00000, idx1=0xC00F0, then done; the next load is accepted in the done cycle.
